niosii_pio_out_pulse: RTL and testbench
=======================================

Name: niosii_pio_out_pulse

Overview:
- Avalon-MM slave output PIO: the write-side counterpart of the switch-input PIO.
- Drives an 18-bit out_port (board LEDs / control lines) from a CPU-writable data register.
- Supports atomic bit-set and bit-clear writes.
- Supports a hardware one-shot pulse: selected bits assert for a programmable number of clocks, then clear themselves without CPU involvement.

Parameters:
- DATA_WIDTH, 18: width of out_port and of the data register.
- RESET_VALUE, 0: value of the data register (and therefore out_port) after reset.
- LEN_WIDTH, 16: width of the pulse length register and of the pulse counter.
- DEFAULT_PULSE_LEN, 1000: pulse length register value after reset, in clocks.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  word address within the slave.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs on a cycle with chipselect=1 and write_n=0.
- writedata  in  32  write data; bits above DATA_WIDTH (or LEN_WIDTH) are ignored.
- readdata  out  32  registered read data, zero-extended.
- out_port  out  DATA_WIDTH  current data register value.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low on reset_n.
- Reset values:
  - data register = RESET_VALUE; out_port = RESET_VALUE.
  - pulse_len = DEFAULT_PULSE_LEN.
  - pulse_mask = 0; counter = 0; readdata = 0.
- Register map (word address):
  - 0 DATA: R/W. A write replaces the data register.
  - 1 reserved: reads 0, writes ignored.
  - 2 PULSE_LEN: R/W, LEN_WIDTH bits.
  - 3 STATUS: read-only. bit0 = busy (counter != 0); bits[DATA_WIDTH:1] = pulse_mask; other bits 0.
  - 4 OUTSET: write-only. data |= writedata.
  - 5 OUTCLEAR: write-only. data &= ~writedata.
  - 6 PULSE: write-only, see pulse engine.
  - 7 reserved: reads 0, writes ignored.
  - Write-only and reserved addresses read 0.
- Read path:
  - readdata is registered every clock from the address mux, independent of chipselect.
  - Read latency is 1 clock.
  - Readback reflects register state before any write in the same cycle.
- Write timing: out_port updates on the clock edge that samples the write; it is visible the next cycle.
- Pulse engine, on a PULSE write with pulse_len != 0:
  - data |= writedata.
  - pulse_mask <= writedata if the counter is expiring that cycle, else pulse_mask | writedata.
  - counter <= pulse_len (retrigger reloads the counter).
- Pulse engine, on a PULSE write with pulse_len == 0: no effect at all.
- Counter:
  - Decrements by 1 each clock while nonzero and not being reloaded.
  - Expiry is the cycle where counter == 1 and no reload occurs. On that edge: data &= ~pulse_mask, pulse_mask <= 0, counter <= 0.
  - Resulting timing: pulsed bits are high for exactly pulse_len clocks of out_port.
- Simultaneous events in one cycle:
  - DATA, OUTSET or OUTCLEAR write coinciding with expiry: apply the write first, then apply the expiry clear of pulse_mask bits. Mask bits end up 0 even if just written to 1.
  - PULSE write coinciding with expiry: the retrigger wins. Old-only mask bits clear; newly written bits stay set; the counter reloads.
- During an active pulse:
  - A PULSE_LEN write does not affect the running counter; it applies to the next PULSE write.
  - An OUTCLEAR of a pulsed bit drops it immediately; its mask bit stays until expiry, which is harmless.
- Reset mid-pulse: everything returns to reset values immediately; there is no pending expiry.

Test Plan:
- Reset: assert reset_n=0 mid-operation -> out_port=0, readdata=0; after release, read address 2 -> 1000 (0x3E8) one cycle later.
- Set/clear: write DATA=0x0000F, then OUTSET=0x30000, then OUTCLEAR=0x00003 -> out_port=0x3000C; read DATA returns 0x3000C with 1-cycle latency.
- Pulse: write PULSE_LEN=5, then PULSE=0x00100 -> out_port bit8 high for exactly 5 clocks, then 0; STATUS reads 0x201 while busy, 0x0 after expiry.
- Retrigger: PULSE_LEN=4; PULSE=0x1 at t0; PULSE=0x2 at t0+2 -> bits 0 and 1 both clear together 4 clocks after the second write; bit 0 is high for 6 clocks total.
- Collisions:
  - OUTSET=0x1 on the expiry cycle of a 0x1 pulse -> bit0 ends at 0.
  - PULSE=0x4 on an expiry cycle of mask 0x1 -> bit0 clears, bit2 stays high for pulse_len clocks.
- Zero length and reserved addresses: PULSE_LEN=0 then PULSE=0xFF -> out_port unchanged, busy=0; writes to addresses 1 and 7 -> no state change; reads of addresses 1, 4, 5, 6, 7 -> 0.

Source files
------------

// File: rtl/niosii_pio_out_pulse_if.sv
// Avalon-MM slave bus bundle for the pulse-capable output PIO.
// The master drives address/strobes/data; the slave returns registered readdata.
interface niosii_pio_out_pulse_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/niosii_pio_out_pulse.sv
// Output PIO with atomic set/clear and a self-clearing one-shot pulse engine.
// out_port mirrors the data register; readdata is registered with one clock of latency.
module niosii_pio_out_pulse #(
  parameter int                    DATA_WIDTH        = 18,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE       = '0,
  parameter int                    LEN_WIDTH         = 16,
  parameter int                    DEFAULT_PULSE_LEN = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  niosii_pio_out_pulse_if.slave avs,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [31:0]           rd_q, rd_d;

  logic                  wr;
  logic                  pulse_wr;
  logic                  cnt_one;
  logic [DATA_WIDTH-1:0] wd_data;
  logic [LEN_WIDTH-1:0]  wd_len;
  logic                  unused_wd;

  assign wr        = avs.chipselect & ~avs.write_n;
  assign wd_data   = avs.writedata[DATA_WIDTH-1:0];
  assign wd_len    = avs.writedata[LEN_WIDTH-1:0];
  assign pulse_wr  = wr && (avs.address == 3'd6) && (len_q != '0);
  assign cnt_one   = (cnt_q == LEN_WIDTH'(1));
  assign unused_wd = ^avs.writedata[31:DATA_WIDTH];

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    len_d  = len_q;
    cnt_d  = cnt_q;

    if (wr) begin
      case (avs.address)
        3'd0:    data_d = wd_data;
        3'd2:    len_d  = wd_len;
        3'd4:    data_d = data_q | wd_data;
        3'd5:    data_d = data_q & ~wd_data;
        default: ;
      endcase
    end

    // A retrigger on the expiry cycle drops only the bits it does not re-pulse.
    if (pulse_wr) begin
      data_d = data_q | wd_data;
      cnt_d  = len_q;
      if (cnt_one) begin
        data_d = data_d & ~(mask_q & ~wd_data);
        mask_d = wd_data;
      end else begin
        mask_d = mask_q | wd_data;
      end
    end else if (cnt_one) begin
      data_d = data_d & ~mask_q;
      mask_d = '0;
      cnt_d  = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LEN_WIDTH'(1);
    end
  end

  always_comb begin
    rd_d = '0;
    case (avs.address)
      3'd0:    rd_d[DATA_WIDTH-1:0] = data_q;
      3'd2:    rd_d[LEN_WIDTH-1:0]  = len_q;
      3'd3:    rd_d[DATA_WIDTH:0]   = {mask_q, (cnt_q != '0)};
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      mask_q <= '0;
      len_q  <= LEN_WIDTH'(DEFAULT_PULSE_LEN);
      cnt_q  <= '0;
      rd_q   <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
    end
  end

  assign out_port     = data_q;
  assign avs.readdata = rd_q;

endmodule

// File: tb/tb_niosii_pio_out_pulse.sv
// Bench for niosii_pio_out_pulse: directed scenarios plus random bus traffic,
// compared against an event-time model that tracks when the active pulse ends.
module tb_niosii_pio_out_pulse;

  logic        clk;
  logic        reset_n;
  logic [17:0] out_port;

  niosii_pio_out_pulse_if bus ();

  niosii_pio_out_pulse dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (bus.slave),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: the pulse is described by its mask and the edge index at which it ends.
  logic [17:0] m_data;
  logic [17:0] m_mask;
  logic [15:0] m_len;
  int          m_end;
  int          c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 18'h0;
    m_mask = 18'h0;
    m_len  = 16'd1000;
    m_end  = 0;
  endtask

  task automatic step(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    logic [31:0] exp_rd;
    logic [17:0] w;
    logic        is_pulse;
    logic        exp_now;
    bus.address    = a;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.writedata  = wd;
    @(posedge clk);
    c++;
    case (a)
      3'd0:    exp_rd = {14'h0, m_data};
      3'd2:    exp_rd = {16'h0, m_len};
      3'd3:    exp_rd = {13'h0, m_mask, (m_end != 0)};
      default: exp_rd = 32'h0;
    endcase
    w        = wd[17:0];
    is_pulse = cs && !wn && (a == 3'd6) && (m_len != 0);
    exp_now  = (m_end != 0) && (m_end == c);
    if (cs && !wn) begin
      case (a)
        3'd0: m_data = w;
        3'd2: m_len  = wd[15:0];
        3'd4: m_data = m_data | w;
        3'd5: m_data = m_data & ~w;
        default: ;
      endcase
    end
    if (is_pulse) begin
      if (exp_now) begin
        m_data = (m_data | w) & ~(m_mask & ~w);
        m_mask = w;
      end else begin
        m_data = m_data | w;
        m_mask = m_mask | w;
      end
      m_end = c + int'(m_len);
    end else if (exp_now) begin
      m_data = m_data & ~m_mask;
      m_mask = 18'h0;
      m_end  = 0;
    end
    #1;
    check("model_readdata", bus.readdata, exp_rd);
    check("model_out_port", {14'h0, out_port}, {14'h0, m_data});
  endtask

  initial begin
    int          hi0;
    int          hi1;
    int          hi2;
    int          hi8;
    logic [31:0] first_st;
    logic [17:0] snap;

    c = 0;
    model_reset();
    reset_n        = 1'b0;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_port", {14'h0, out_port}, 32'h0);
    check("reset_readdata", bus.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset in the middle of a long default-length pulse.
    step(3'd6, 1'b1, 1'b0, 32'h3);
    step(3'd3, 1'b0, 1'b1, 32'h0);
    check("busy_before_reset", bus.readdata, 32'h7);
    #3;
    reset_n = 1'b0;
    #1;
    check("midreset_out_port", {14'h0, out_port}, 32'h0);
    check("midreset_readdata", bus.readdata, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(3'd2, 1'b0, 1'b1, 32'h0);
    check("default_pulse_len", bus.readdata, 32'h3E8);
    step(3'd3, 1'b0, 1'b1, 32'h0);
    check("status_after_reset", bus.readdata, 32'h0);

    // Set / clear.
    step(3'd0, 1'b1, 1'b0, 32'h0000F);
    step(3'd4, 1'b1, 1'b0, 32'h30000);
    step(3'd5, 1'b1, 1'b0, 32'h00003);
    check("setclear_out_port", {14'h0, out_port}, 32'h3000C);
    step(3'd0, 1'b1, 1'b1, 32'h0);
    check("read_data_reg", bus.readdata, 32'h3000C);

    // Single pulse of 5 clocks on bit 8.
    step(3'd2, 1'b1, 1'b0, 32'd5);
    step(3'd6, 1'b1, 1'b0, 32'h00100);
    hi8 = out_port[8] ? 1 : 0;
    first_st = 32'h0;
    for (int i = 0; i < 8; i++) begin
      step(3'd3, 1'b0, 1'b1, 32'h0);
      if (i == 0) first_st = bus.readdata;
      if (out_port[8]) hi8++;
    end
    check("pulse_high_clocks", hi8, 5);
    check("status_busy", first_st, 32'h201);
    check("status_after_expiry", bus.readdata, 32'h0);

    // Retrigger: bit 1 pulsed two clocks after bit 0.
    step(3'd2, 1'b1, 1'b0, 32'd4);
    hi0 = 0;
    hi1 = 0;
    step(3'd6, 1'b1, 1'b0, 32'h1);
    if (out_port[0]) hi0++;
    step(3'd3, 1'b0, 1'b1, 32'h0);
    if (out_port[0]) hi0++;
    step(3'd6, 1'b1, 1'b0, 32'h2);
    if (out_port[0]) hi0++;
    if (out_port[1]) hi1++;
    for (int i = 0; i < 6; i++) begin
      step(3'd3, 1'b0, 1'b1, 32'h0);
      if (out_port[0]) hi0++;
      if (out_port[1]) hi1++;
      if (out_port[0] != out_port[1]) check("retrigger_bits_together", {30'h0, out_port[1:0]}, 32'h3);
    end
    check("retrigger_bit0_clocks", hi0, 6);
    check("retrigger_bit1_clocks", hi1, 4);

    // OUTSET of a pulsed bit on its expiry cycle.
    step(3'd2, 1'b1, 1'b0, 32'd1);
    step(3'd6, 1'b1, 1'b0, 32'h1);
    step(3'd4, 1'b1, 1'b0, 32'h1);
    check("outset_on_expiry", {31'h0, out_port[0]}, 32'h0);

    // PULSE on the expiry cycle of a different mask.
    step(3'd0, 1'b1, 1'b0, 32'h0);
    step(3'd2, 1'b1, 1'b0, 32'd3);
    step(3'd6, 1'b1, 1'b0, 32'h1);
    step(3'd3, 1'b0, 1'b1, 32'h0);
    step(3'd3, 1'b0, 1'b1, 32'h0);
    step(3'd6, 1'b1, 1'b0, 32'h4);
    check("retrigger_on_expiry", {29'h0, out_port[2:0]}, 32'h4);
    hi2 = 1;
    for (int i = 0; i < 5; i++) begin
      step(3'd3, 1'b0, 1'b1, 32'h0);
      if (out_port[2]) hi2++;
    end
    check("retrigger_new_bit_clocks", hi2, 3);

    // Zero length pulse and reserved addresses.
    step(3'd0, 1'b1, 1'b0, 32'h2A5A5);
    snap = out_port;
    step(3'd2, 1'b1, 1'b0, 32'd0);
    step(3'd6, 1'b1, 1'b0, 32'hFF);
    step(3'd1, 1'b1, 1'b0, 32'hFFFFFFFF);
    step(3'd7, 1'b1, 1'b0, 32'hFFFFFFFF);
    check("zero_len_out_unchanged", {14'h0, out_port}, {14'h0, snap});
    step(3'd3, 1'b0, 1'b1, 32'h0);
    check("zero_len_not_busy", bus.readdata, 32'h0);
    step(3'd2, 1'b0, 1'b1, 32'h0);
    check("len_after_zero", bus.readdata, 32'h0);
    step(3'd1, 1'b0, 1'b1, 32'h0);
    check("read_addr1", bus.readdata, 32'h0);
    step(3'd4, 1'b0, 1'b1, 32'h0);
    check("read_addr4", bus.readdata, 32'h0);
    step(3'd5, 1'b0, 1'b1, 32'h0);
    check("read_addr5", bus.readdata, 32'h0);
    step(3'd6, 1'b0, 1'b1, 32'h0);
    check("read_addr6", bus.readdata, 32'h0);
    step(3'd7, 1'b0, 1'b1, 32'h0);
    check("read_addr7", bus.readdata, 32'h0);

    // Random traffic with short pulse lengths.
    for (int i = 0; i < 800; i++) begin
      logic [2:0]  ra;
      logic        rcs;
      logic        rwn;
      logic [31:0] rwd;
      ra  = 3'($urandom_range(0, 7));
      rcs = ($urandom_range(0, 9) != 0);
      rwn = ($urandom_range(0, 2) == 0);
      rwd = $urandom;
      if (ra == 3'd2) rwd = 32'($urandom_range(0, 7)) | (rwd & 32'hFFFF0000);
      if (ra == 3'd6) rwd = rwd & 32'hFFFF000F;
      step(ra, rcs, rwn, rwd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
